// File: rtl/regwr_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by the top: REGWR_PERF_CNT_EN (performance counters).
package regwr_pkg;

  localparam int DATA_W_DEF = 32;  // default write data width
  localparam int ADDR_W_DEF = 5;   // default register select width
  localparam int ZERO_REG   = 0;   // hard-wired zero register index

  // Requester ids, also the bit positions in the arbiter req/grant vectors
  localparam int REQ_ALU    = 0;
  localparam int REQ_MEM    = 1;

  localparam int CNT_W      = 16;  // performance counter width

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter; remembers the last granted requester.
// Latency: grant is combinational from req/hold; last_grant updates at the clock edge.
// Backpressure: hold=1 blocks all grants and freezes last_grant.
// Ports: clk, rst (async active-high), req[1:0], hold -> grant[1:0] (one-hot or zero).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] grant
);

  // 0 = requester 0 won last, 1 = requester 1 won last
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (!hold) begin
      if (req == 2'b11) begin
        // Contested: favour the requester that did not win last time
        grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
    // A grant is always a handshake, since grant implies the request is valid
    if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end
  end

  // Reset to 1 so requester 0 wins the first contested cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between r0 (ALU) and r1 (load) via round-robin.
// Latency: 1 cycle from handshake to wr_en/wr_sel/wr_data; one write per cycle sustained.
// Backpressure: rN_ready combinational from valids, hold and last grant; hold=1 stalls both.
// Ports: clk, rst (async active-high), hold, r0_*/r1_* valid/ready/addr/data requesters,
//        wr_en/wr_sel/wr_data registered write port.
// Optional: `define REGWR_PERF_CNT_EN adds grant_cnt0, grant_cnt1, conflict_cnt (saturating).
module regfile_wr_arbiter
  import regwr_pkg::*;
#(
  parameter int DATA_W           = DATA_W_DEF,
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_sel,
  output logic [DATA_W-1:0] wr_data
`ifdef REGWR_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  logic [1:0] req;
  logic [1:0] grant;

  assign req[REQ_ALU] = r0_valid;
  assign req[REQ_MEM] = r1_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .hold  (hold),
    .grant (grant)
  );

  assign r0_ready = grant[REQ_ALU];
  assign r1_ready = grant[REQ_MEM];

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_sel_q,  wr_sel_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              hs;
  logic              discard;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    hs       = |grant;
    win_addr = grant[REQ_MEM] ? r1_addr : r0_addr;
    win_data = grant[REQ_MEM] ? r1_data : r0_data;
    // Writes to the zero register still complete the handshake but never reach the file
    discard  = ZERO_REG_DISCARD && (win_addr == ADDR_W'(ZERO_REG));

    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    if (hs && !discard) begin
      wr_en_d   = 1'b1;
      wr_sel_d  = win_addr;
      wr_data_d = win_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;

`ifdef REGWR_PERF_CNT_EN
  logic [CNT_W-1:0] grant_cnt0_q,   grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q,   grant_cnt1_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating increments: counters stick at all-ones
  always_comb begin
    grant_cnt0_d   = grant_cnt0_q;
    grant_cnt1_d   = grant_cnt1_q;
    conflict_cnt_d = conflict_cnt_q;
    if (grant[REQ_ALU] && (grant_cnt0_q != '1)) begin
      grant_cnt0_d = grant_cnt0_q + 1'b1;
    end
    if (grant[REQ_MEM] && (grant_cnt1_q != '1)) begin
      grant_cnt1_d = grant_cnt1_q + 1'b1;
    end
    if (!hold && r0_valid && r1_valid && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed-vector bench for regfile_wr_arbiter.
// Drives inputs 1 time unit after the rising edge; checks readies 1 unit later and
// registered outputs 1 unit after the following rising edge.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        r0_valid, r0_ready;
  logic [4:0]  r0_addr;
  logic [31:0] r0_data;
  logic        r1_valid, r1_ready;
  logic [4:0]  r1_addr;
  logic [31:0] r1_data;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [31:0] wr_data;
`ifdef REGWR_PERF_CNT_EN
  logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  int vectors;
  int miscompares;

  regfile_wr_arbiter #(
    .DATA_W           (32),
    .ADDR_W           (5),
    .ZERO_REG_DISCARD (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_addr  (r0_addr),
    .r0_data  (r0_data),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_addr  (r1_addr),
    .r1_data  (r1_data),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data)
`ifdef REGWR_PERF_CNT_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check readies now, then take one clock and check the registered write port.
  task automatic step(input string tag, input logic er0, input logic er1,
                      input logic een, input logic [4:0] esel, input logic [31:0] edat);
    #1;
    chk({tag, ".r0_ready"}, {31'd0, r0_ready}, {31'd0, er0});
    chk({tag, ".r1_ready"}, {31'd0, r1_ready}, {31'd0, er1});
    @(posedge clk);
    #1;
    chk({tag, ".wr_en"},   {31'd0, wr_en},  {31'd0, een});
    chk({tag, ".wr_sel"},  {27'd0, wr_sel}, {27'd0, esel});
    chk({tag, ".wr_data"}, wr_data,         edat);
  endtask

  // Expected grant order for four contested cycles after reset
  logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    hold     = 1'b0;
    r0_valid = 1'b0; r0_addr = '0; r0_data = '0;
    r1_valid = 1'b0; r1_addr = '0; r1_data = '0;

    // Reset state
    #2;
    chk("reset.wr_en",   {31'd0, wr_en},  32'd0);
    chk("reset.wr_sel",  {27'd0, wr_sel}, 32'd0);
    chk("reset.wr_data", wr_data,         32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Contested alternation: r0, r1, r0, r1
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'hAAAA_0003;
    r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'hBBBB_0007;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("alt%0d", i), !exp_g[i], exp_g[i], 1'b1,
           exp_g[i] ? 5'd7 : 5'd3, exp_g[i] ? 32'hBBBB_0007 : 32'hAAAA_0003);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    step("alt_idle", 1'b0, 1'b0, 1'b0, 5'd7, 32'hBBBB_0007);

    // Same address from both: r0 (last was r1) lands first, r1 data ends up final
    r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 32'd1;
    r1_valid = 1'b1; r1_addr = 5'd9; r1_data = 32'd2;
    step("same_a", 1'b1, 1'b0, 1'b1, 5'd9, 32'd1);
    r0_valid = 1'b0;
    step("same_b", 1'b0, 1'b1, 1'b1, 5'd9, 32'd2);
    r1_valid = 1'b0;

    // Single requester r0, one-cycle latency, then strobe drops
    r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'hDEAD_BEEF;
    step("r0_only", 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    r0_valid = 1'b0;
    step("r0_drop", 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF);

    // Write to register 0 is accepted but discarded
    r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'h0000_FFFF;
    step("zero_reg", 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF);
    r1_valid = 1'b0;

    // Hold with both valid: nothing granted; last grant (r1, from the discarded write) kept
    hold = 1'b1;
    r0_valid = 1'b1; r0_addr = 5'd11; r0_data = 32'h0000_1111;
    r1_valid = 1'b1; r1_addr = 5'd12; r1_data = 32'h0000_2222;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF);
    end
    hold = 1'b0;
    step("hold_release", 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_1111);
    r0_valid = 1'b0; r1_valid = 1'b0;
`ifdef REGWR_PERF_CNT_EN
    chk("grant_cnt0",   {16'd0, grant_cnt0},   32'd5);
    chk("grant_cnt1",   {16'd0, grant_cnt1},   32'd4);
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd6);
`endif

    // Asynchronous reset mid-cycle while wr_en=1 (last grant is r0 at this point)
    #3;
    rst = 1'b1;
    #1;
    chk("arst.wr_en",   {31'd0, wr_en},  32'd0);
    chk("arst.wr_sel",  {27'd0, wr_sel}, 32'd0);
    chk("arst.wr_data", wr_data,         32'd0);
`ifdef REGWR_PERF_CNT_EN
    chk("arst.conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // After reset r0 again wins the first contested cycle
    r0_valid = 1'b1; r1_valid = 1'b1;
    step("post_rst", 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_1111);
    r0_valid = 1'b0;
    step("post_rst_r1", 1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_2222);
    r1_valid = 1'b0;
    step("final_idle", 1'b0, 1'b0, 1'b0, 5'd12, 32'h0000_2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
